// File: rtl/multicycle_mem_responder.sv
// Fixed-latency memory responder for the multi-cycle CPU's unified memory port.
// Each accepted request is answered with a one-cycle mem_ready pulse LATENCY cycles later.
module multicycle_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WORD_W    = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] DEPTH_LIM = WORD_W'(DEPTH_WORDS);
    localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("multicycle_mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;
    logic                    accept;
    logic                    go_resp;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    read_q;
    logic                    write_q;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic                    sel_read;
    logic                    sel_write;
    logic                    sel_oor;
    logic [IDX_W-1:0]        word_idx;
    logic                    do_write;
    logic                    do_read;
    logic                    unused_addr_bits;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // With LATENCY==1 the access happens on the accepting edge, so live inputs are used
    always_comb begin
        sel_addr  = addr_q;
        sel_din   = din_q;
        sel_read  = read_q;
        sel_write = write_q;
        if (state == IDLE) begin
            sel_addr  = addr;
            sel_din   = din;
            sel_read  = mem_read;
            sel_write = mem_write;
        end
    end

    assign sel_oor          = (sel_addr[ADDR_WIDTH-1:2] >= DEPTH_LIM);
    assign word_idx         = sel_addr[IDX_W+1:2];
    assign do_write         = go_resp & sel_write & ~sel_read & ~sel_oor & ~reset;
    assign do_read          = go_resp & sel_read & ~sel_write;
    assign unused_addr_bits = ^sel_addr[1:0];

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read | mem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            din_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            dout      <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_ready <= go_resp;
            busy      <= (state_next != IDLE);
            err       <= go_resp & ((sel_read & sel_write) | sel_oor);
            if (accept) begin
                addr_q  <= addr;
                din_q   <= din;
                read_q  <= mem_read;
                write_q <= mem_write;
            end
            if (do_read) begin
                dout <= sel_oor ? '0 : mem[word_idx];
            end
        end
    end

    // Storage is never cleared
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= sel_din;
        end
    end

endmodule
